// File: rtl/cmd_dvb_demux.sv
// Store-and-forward DVB command demultiplexer: buffers each input frame, validates
// its header when the frame ends, then replays it unmodified to one of NUM_CH channels.
module cmd_dvb_demux #(
  parameter int         NUM_CH   = 4,
  parameter int         CH_W     = 2,
  parameter logic [7:0] CMD_TYPE = 8'h40,
  parameter int         MAX_LEN  = 256,
  parameter int         BUF_AW   = 9,
  parameter int         DESC_AW  = 3
) (
  input  logic              clk_main,
  input  logic              rst,
  input  logic [7:0]        cmd_din,
  input  logic              cmd_din_en,
  output logic [7:0]        cmd_dout,
  output logic [NUM_CH-1:0] cmd_dout_en,
  output logic              cmd_dout_sof,
  output logic              cmd_dout_eof,
  output logic [CH_W-1:0]   cmd_dout_ch,
  output logic [15:0]       ok_cnt,
  output logic [15:0]       drop_cnt
);
  localparam int LEN_W  = $clog2(MAX_LEN + 1) + 1;
  localparam int BUF_D  = 1 << BUF_AW;
  localparam int DESC_D = 1 << DESC_AW;
  localparam logic [LEN_W-1:0]  MAX_LEN_V = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0]  MIN_LEN_V = LEN_W'(4);
  localparam logic [LEN_W-1:0]  LEN_ONE   = LEN_W'(1);
  localparam logic [7:0]        NUM_CH_V  = 8'(NUM_CH);
  localparam logic [BUF_AW-1:0] PTR_ONE   = BUF_AW'(1);
  localparam logic [DESC_AW-1:0] DPTR_ONE = DESC_AW'(1);
  localparam logic [DESC_AW:0]  CNT_ONE   = (DESC_AW+1)'(1);

  typedef enum logic [1:0] {IDLE, SEND, GAP} rd_state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [LEN_W-1:0] sat_inc_len(input logic [LEN_W-1:0] v);
    return (v == {LEN_W{1'b1}}) ? v : v + LEN_ONE;
  endfunction

  function automatic logic [NUM_CH-1:0] ch_onehot(input logic [CH_W-1:0] c);
    logic [NUM_CH-1:0] oh;
    oh    = '0;
    oh[c] = 1'b1;
    return oh;
  endfunction

  logic [7:0]        buf_mem [BUF_D];
  logic [BUF_AW-1:0] wr_ptr, rd_ptr, frm_start, used;
  logic              in_frame, bad;
  logic [LEN_W-1:0]  len;
  logic [7:0]        hdr0, hdr1;
  logic              full, wr_en, frm_end, accept, ok_pls, drop_pls;

  logic [CH_W-1:0]    desc_ch  [DESC_D];
  logic [LEN_W-1:0]   desc_len [DESC_D];
  logic [DESC_AW-1:0] dw_ptr, dr_ptr;
  logic [DESC_AW:0]   desc_cnt;
  logic               desc_full, desc_empty, push, pop;

  rd_state_t        state, state_nxt;
  logic             rd_en, first;
  logic [LEN_W-1:0] rem;
  logic [CH_W-1:0]  cur_ch;

  logic [7:0]      data_p0;
  logic            vld_p0, sof_p0, eof_p0;
  logic [CH_W-1:0] ch_p0;

  // One slot is kept free so that wr_ptr == rd_ptr always means empty.
  assign used       = wr_ptr - rd_ptr;
  assign full       = (used == {BUF_AW{1'b1}});
  assign wr_en      = cmd_din_en && !full && !(in_frame && bad);
  assign frm_end    = in_frame && !cmd_din_en;
  assign desc_full  = desc_cnt[DESC_AW];
  assign desc_empty = (desc_cnt == '0);
  assign accept     = frm_end && !bad && !desc_full && (len >= MIN_LEN_V) &&
                      (len <= MAX_LEN_V) && (hdr0 == CMD_TYPE) && (hdr1 < NUM_CH_V);
  assign push       = accept;

  always_ff @(posedge clk_main or posedge rst) begin
    if (rst) begin
      in_frame  <= 1'b0;
      bad       <= 1'b0;
      len       <= '0;
      wr_ptr    <= '0;
      frm_start <= '0;
      ok_pls    <= 1'b0;
      drop_pls  <= 1'b0;
      ok_cnt    <= '0;
      drop_cnt  <= '0;
    end else begin
      ok_pls   <= accept;
      drop_pls <= frm_end && !accept;
      if (ok_pls)   ok_cnt   <= sat_inc16(ok_cnt);
      if (drop_pls) drop_cnt <= sat_inc16(drop_cnt);
      if (cmd_din_en) begin
        in_frame <= 1'b1;
        if (!in_frame) begin
          frm_start <= wr_ptr;
          len       <= LEN_ONE;
          bad       <= full;
        end else begin
          len <= sat_inc_len(len);
          if (full) bad <= 1'b1;
        end
        if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
      end else if (in_frame) begin
        in_frame <= 1'b0;
        if (!accept) wr_ptr <= frm_start;
      end
    end
  end

  always_ff @(posedge clk_main) begin
    if (wr_en) buf_mem[wr_ptr] <= cmd_din;
    if (cmd_din_en && !in_frame) hdr0 <= cmd_din;
    if (cmd_din_en && in_frame && (len == LEN_ONE)) hdr1 <= cmd_din;
    if (push) begin
      desc_ch[dw_ptr]  <= hdr1[CH_W-1:0];
      desc_len[dw_ptr] <= len;
    end
    data_p0 <= buf_mem[rd_ptr];
  end

  always_ff @(posedge clk_main or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      dw_ptr   <= '0;
      dr_ptr   <= '0;
      desc_cnt <= '0;
      rd_ptr   <= '0;
      rem      <= '0;
      cur_ch   <= '0;
      first    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (push) dw_ptr <= dw_ptr + DPTR_ONE;
      if (pop)  dr_ptr <= dr_ptr + DPTR_ONE;
      case ({push, pop})
        2'b10:   desc_cnt <= desc_cnt + CNT_ONE;
        2'b01:   desc_cnt <= desc_cnt - CNT_ONE;
        default: ;
      endcase
      if (pop) begin
        rem    <= desc_len[dr_ptr];
        cur_ch <= desc_ch[dr_ptr];
        first  <= 1'b1;
      end else if (rd_en) begin
        rem    <= rem - LEN_ONE;
        rd_ptr <= rd_ptr + PTR_ONE;
        first  <= 1'b0;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    rd_en     = 1'b0;
    case (state)
      IDLE: if (!desc_empty) begin
        pop       = 1'b1;
        state_nxt = SEND;
      end
      SEND: begin
        rd_en = 1'b1;
        if (rem == LEN_ONE) state_nxt = GAP;
      end
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_main or posedge rst) begin
    if (rst) begin
      vld_p0       <= 1'b0;
      sof_p0       <= 1'b0;
      eof_p0       <= 1'b0;
      ch_p0        <= '0;
      cmd_dout     <= '0;
      cmd_dout_en  <= '0;
      cmd_dout_sof <= 1'b0;
      cmd_dout_eof <= 1'b0;
      cmd_dout_ch  <= '0;
    end else begin
      // Stage p0: buffer read in flight, frame markers travel with it
      vld_p0 <= rd_en;
      sof_p0 <= rd_en && first;
      eof_p0 <= rd_en && (rem == LEN_ONE);
      ch_p0  <= cur_ch;
      // Stage p1: registered outputs
      cmd_dout_en  <= vld_p0 ? ch_onehot(ch_p0) : '0;
      cmd_dout_sof <= sof_p0;
      cmd_dout_eof <= eof_p0;
      if (vld_p0) begin
        cmd_dout    <= data_p0;
        cmd_dout_ch <= ch_p0;
      end
    end
  end
endmodule

// File: tb/tb_cmd_dvb_demux.sv
// Directed and randomized bench for cmd_dvb_demux, checked against a frame-level
// reference model of acceptance, descriptor occupancy and replay timing.
module tb_cmd_dvb_demux;
  logic        clk_main = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  cmd_din = 8'd0;
  logic        cmd_din_en = 1'b0;
  logic [7:0]  cmd_dout;
  logic [3:0]  cmd_dout_en;
  logic        cmd_dout_sof, cmd_dout_eof;
  logic [1:0]  cmd_dout_ch;
  logic [15:0] ok_cnt, drop_cnt;

  cmd_dvb_demux dut (
    .clk_main(clk_main), .rst(rst), .cmd_din(cmd_din), .cmd_din_en(cmd_din_en),
    .cmd_dout(cmd_dout), .cmd_dout_en(cmd_dout_en), .cmd_dout_sof(cmd_dout_sof),
    .cmd_dout_eof(cmd_dout_eof), .cmd_dout_ch(cmd_dout_ch), .ok_cnt(ok_cnt),
    .drop_cnt(drop_cnt)
  );

  always #5 clk_main = ~clk_main;

  int edge_n = 0;
  always @(posedge clk_main) edge_n <= edge_n + 1;

  typedef struct { int ch; int len; int start; } exp_t;
  exp_t       exp_q[$];
  logic [7:0] exp_b[$];
  logic [7:0] fr[$];
  int         pop_l[$];
  int total = 0, bad = 0;
  int last_free = 0, m_ok = 0, m_drop = 0, mon_pos = 0, last_eof = -10;
  int ok0, drop0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Payload is either random or the counting pattern 00,01,00,01,02,... used by the directed frames.
  task automatic build(input logic [7:0] b0, input logic [7:0] b1, input int n, input bit rnd);
    logic [7:0] v;
    fr.delete();
    for (int i = 0; i < n; i++) begin
      if (i == 0) v = b0;
      else if (i == 1) v = b1;
      else if (rnd) v = 8'($urandom);
      else if (i == 2) v = 8'd0;
      else if (i == 3) v = 8'd1;
      else v = 8'(i - 4);
      fr.push_back(v);
    end
  endtask

  // Frame-level model: accept rules, descriptor occupancy at the end edge, and
  // replay schedule (pop one edge after push or after previous len+2 cycles).
  task automatic model_end(input int t);
    int n, occ, pe;
    bit ok;
    exp_t e;
    n  = fr.size();
    ok = 1'b0;
    if (n >= 4 && n <= 256) ok = (fr[0] == 8'h40) && (fr[1] < 8'd4);
    occ = 0;
    foreach (pop_l[i]) if (pop_l[i] >= t) occ++;
    if (occ >= 8) ok = 1'b0;
    if (ok) begin
      pe = (t + 1 > last_free) ? t + 1 : last_free;
      last_free = pe + n + 2;
      pop_l.push_back(pe);
      e.ch = int'(fr[1]); e.len = n; e.start = pe + 2;
      exp_q.push_back(e);
      foreach (fr[i]) exp_b.push_back(fr[i]);
      m_ok++;
    end else begin
      m_drop++;
    end
  endtask

  task automatic send_frame(input int gap);
    foreach (fr[i]) begin
      cmd_din = fr[i]; cmd_din_en = 1'b1;
      @(posedge clk_main); #1;
    end
    cmd_din_en = 1'b0;
    @(posedge clk_main); #1;
    model_end(edge_n);
    repeat (gap - 1) begin @(posedge clk_main); #1; end
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 3000) begin @(posedge clk_main); #1; k++; end
    chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    repeat (3) begin @(posedge clk_main); #1; end
  endtask

  task automatic chk_cnts(input string tag);
    chk({tag, "_ok_cnt"}, 32'(ok_cnt), 32'(m_ok));
    chk({tag, "_drop_cnt"}, 32'(drop_cnt), 32'(m_drop));
  endtask

  always @(negedge clk_main) begin
    if (!rst) begin
      if (cmd_dout_en != 4'd0) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", 32'(cmd_dout_en), 32'd0);
        end else begin
          if (mon_pos == 0) chk("idle_between", 32'(edge_n - last_eof > 1), 32'd1);
          chk("byte_edge", 32'(edge_n), 32'(exp_q[0].start + mon_pos));
          chk("dout_en", 32'(cmd_dout_en), 32'(1 << exp_q[0].ch));
          chk("dout_ch", 32'(cmd_dout_ch), 32'(exp_q[0].ch));
          chk("dout", 32'(cmd_dout), 32'(exp_b[0]));
          chk("sof", 32'(cmd_dout_sof), 32'(mon_pos == 0));
          chk("eof", 32'(cmd_dout_eof), 32'(mon_pos == exp_q[0].len - 1));
          if (cmd_dout_eof) last_eof = edge_n;
          void'(exp_b.pop_front());
          mon_pos++;
          if (mon_pos == exp_q[0].len) begin
            void'(exp_q.pop_front());
            mon_pos = 0;
          end
        end
      end else begin
        chk("idle_flags", 32'({cmd_dout_sof, cmd_dout_eof}), 32'd0);
        if (exp_q.size() != 0 && edge_n >= exp_q[0].start + mon_pos) begin
          chk("missing_byte", 32'(cmd_dout_en), 32'(1 << exp_q[0].ch));
          for (int i = mon_pos; i < exp_q[0].len; i++) void'(exp_b.pop_front());
          void'(exp_q.pop_front());
          mon_pos = 0;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, g;
    logic [7:0] b0, b1;
    rst = 1'b1;
    repeat (3) @(posedge clk_main);
    #1;
    chk("rst_en", 32'(cmd_dout_en), 32'd0);
    chk("rst_sof", 32'(cmd_dout_sof), 32'd0);
    chk("rst_eof", 32'(cmd_dout_eof), 32'd0);
    chk("rst_dout", 32'(cmd_dout), 32'd0);
    chk("rst_ch", 32'(cmd_dout_ch), 32'd0);
    chk("rst_ok", 32'(ok_cnt), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    rst = 1'b0;
    repeat (2) begin @(posedge clk_main); #1; end

    // basic ch1 frame
    build(8'h40, 8'h01, 14, 1'b0); send_frame(1);
    drain();
    chk_cnts("t1");
    chk("t1_ok_hand", 32'(ok_cnt), 32'd1);

    // bad type then a good ch2 frame
    build(8'h41, 8'h01, 14, 1'b0); send_frame(1);
    build(8'h40, 8'h02, 10, 1'b0); send_frame(1);
    drain();
    chk_cnts("t2");
    chk("t2_drop_hand", 32'(drop_cnt), 32'd1);

    // bad channel, runt, oversize; then max-length and min-length frames
    ok0 = int'(ok_cnt); drop0 = int'(drop_cnt);
    build(8'h40, 8'h05, 14, 1'b0);  send_frame(1);
    build(8'h40, 8'h00, 3, 1'b0);   send_frame(1);
    build(8'h40, 8'h00, 257, 1'b0); send_frame(1);
    repeat (4) begin @(posedge clk_main); #1; end
    chk("t3_drop_delta", 32'(int'(drop_cnt) - drop0), 32'd3);
    chk("t3_ok_delta", 32'(int'(ok_cnt) - ok0), 32'd0);
    build(8'h40, 8'h03, 256, 1'b0); send_frame(1);
    build(8'h40, 8'h00, 4, 1'b0);   send_frame(1);
    drain();
    chk_cnts("t3");

    // ch0 and ch3 frames with minimum gap
    build(8'h40, 8'h00, 14, 1'b0); send_frame(1);
    build(8'h40, 8'h03, 20, 1'b0); send_frame(1);
    drain();
    chk_cnts("t4");

    // long replay keeps the reader busy while nine short frames fill the descriptor FIFO
    ok0 = int'(ok_cnt); drop0 = int'(drop_cnt);
    build(8'h40, 8'h00, 200, 1'b1); send_frame(1);
    for (int i = 0; i < 9; i++) begin
      build(8'h40, 8'(i % 4), 4, 1'b1); send_frame(1);
    end
    drain();
    chk_cnts("t5");
    chk("t5_ok_delta", 32'(int'(ok_cnt) - ok0), 32'd9);
    chk("t5_drop_delta", 32'(int'(drop_cnt) - drop0), 32'd1);

    // randomized frames
    for (int i = 0; i < 30; i++) begin
      n  = $urandom_range(1, 40);
      b0 = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'h40;
      b1 = 8'($urandom_range(0, 5));
      g  = $urandom_range(1, 4);
      build(b0, b1, n, 1'b1); send_frame(g);
    end
    drain();
    chk_cnts("rnd");

    // reset during the 6th byte of a frame while a replay is running
    build(8'h40, 8'h01, 14, 1'b0); send_frame(1);
    build(8'h40, 8'h02, 20, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cmd_din = fr[i]; cmd_din_en = 1'b1;
      @(posedge clk_main); #1;
    end
    chk("pre_rst_active", 32'(cmd_dout_en != 4'd0), 32'd1);
    cmd_din = fr[5];
    rst = 1'b1;
    exp_q.delete(); exp_b.delete(); pop_l.delete();
    mon_pos = 0; last_free = 0; m_ok = 0; m_drop = 0;
    #1;
    chk("arst_en", 32'(cmd_dout_en), 32'd0);
    chk("arst_sof_eof", 32'({cmd_dout_sof, cmd_dout_eof}), 32'd0);
    chk("arst_dout", 32'(cmd_dout), 32'd0);
    chk("arst_ch", 32'(cmd_dout_ch), 32'd0);
    chk_cnts("arst");
    @(posedge clk_main); #1;
    cmd_din_en = 1'b0;
    repeat (3) begin @(posedge clk_main); #1; end
    rst = 1'b0;
    repeat (3) begin @(posedge clk_main); #1; end
    build(8'h40, 8'h01, 14, 1'b0); send_frame(1);
    drain();
    chk_cnts("post_rst");
    chk("post_rst_ok_hand", 32'(ok_cnt), 32'd1);
    chk("final_queue", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
